// File: rtl/ram8x72_ctrl.sv
// Request/response front end for the 8x72 DFF RAM. It hides the wr_n/address pin
// protocol, and can sweep the array to INIT_VAL after reset.
module ram8x72_ctrl #(
   parameter int            DW       = 72,
   parameter int            AW       = 3,
   parameter int            RD_LAT   = 2,
   parameter bit            INIT_EN  = 1'b1,
   parameter logic [DW-1:0] INIT_VAL = '0
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          req_valid_i,
   output logic          req_ready_o,
   input  logic          req_write_i,
   input  logic [AW-1:0] req_addr_i,
   input  logic [DW-1:0] req_wdata_i,
   output logic          rsp_valid_o,
   input  logic          rsp_ready_i,
   output logic [DW-1:0] rsp_rdata_o,
   output logic          init_done_o,
   output logic          ram_wr_n_o,
   output logic [AW-1:0] ram_address_o,
   output logic [DW-1:0] ram_wdata_o,
   input  logic [DW-1:0] ram_rdata_i
);
   localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [2:0] {S_INIT, S_IDLE, S_WRITE, S_READ, S_RSP} state_e;

   state_e        state_q, state_d;
   logic [AW:0]   init_cnt_q, init_cnt_d;
   logic [LW-1:0] lat_q, lat_d;
   logic          req_ready_q, req_ready_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
   logic          init_done_q, init_done_d;
   logic          wr_n_q, wr_n_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= INIT_EN ? S_INIT : S_IDLE;
         init_cnt_q  <= '0;
         lat_q       <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         init_done_q <= 1'b0;
         wr_n_q      <= 1'b1;
         addr_q      <= '0;
         wdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         lat_q       <= lat_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         init_done_q <= init_done_d;
         wr_n_q      <= wr_n_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      init_cnt_d  = init_cnt_q;
      lat_d       = lat_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      init_done_d = init_done_q;
      wr_n_d      = 1'b1;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      case (state_q)
         S_INIT: begin
            req_ready_d = 1'b0;
            // The MSB of the counter marks that every address has been written.
            if (init_cnt_q[AW]) begin
               init_done_d = 1'b1;
               req_ready_d = 1'b1;
               state_d     = S_IDLE;
            end else begin
               wr_n_d     = 1'b0;
               addr_d     = init_cnt_q[AW-1:0];
               wdata_d    = INIT_VAL;
               init_cnt_d = init_cnt_q + (AW+1)'(1);
            end
         end
         S_IDLE: begin
            req_ready_d = 1'b1;
            if (req_valid_i && req_ready_q) begin
               req_ready_d = 1'b0;
               addr_d      = req_addr_i;
               if (req_write_i) begin
                  wr_n_d  = 1'b0;
                  wdata_d = req_wdata_i;
                  state_d = S_WRITE;
               end else begin
                  lat_d   = '0;
                  state_d = S_READ;
               end
            end
         end
         S_WRITE: begin
            req_ready_d = 1'b1;
            state_d     = S_IDLE;
         end
         S_READ: begin
            if (lat_q == LW'(RD_LAT - 1)) begin
               rsp_rdata_d = ram_rdata_i;
               rsp_valid_d = 1'b1;
               state_d     = S_RSP;
            end else begin
               lat_d = lat_q + LW'(1);
            end
         end
         S_RSP: begin
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign req_ready_o   = req_ready_q;
   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_rdata_o   = rsp_rdata_q;
   assign init_done_o   = init_done_q;
   assign ram_wr_n_o    = wr_n_q;
   assign ram_address_o = addr_q;
   assign ram_wdata_o   = wdata_q;

endmodule

// File: tb/tb_ram8x72_ctrl.sv
// Directed bench for ram8x72_ctrl: default instance (INIT_EN=1, RD_LAT=2) plus
// an INIT_EN=0, RD_LAT=1 instance, each wired to a behavioural 8x72 RAM.
module tb_ram8x72_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_rst, a_req_valid, a_req_ready, a_req_write, a_rsp_valid, a_rsp_ready;
   logic        a_init_done, a_ram_wr_n;
   logic [2:0]  a_req_addr, a_ram_address;
   logic [71:0] a_req_wdata, a_rsp_rdata, a_ram_wdata, a_ram_rdata;

   logic        b_rst, b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready;
   logic        b_init_done, b_ram_wr_n;
   logic [2:0]  b_req_addr, b_ram_address;
   logic [71:0] b_req_wdata, b_rsp_rdata, b_ram_wdata, b_ram_rdata;

   ram8x72_ctrl u_a (
      .clk_i(clk), .rst_i(a_rst),
      .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_write_i(a_req_write),
      .req_addr_i(a_req_addr), .req_wdata_i(a_req_wdata),
      .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready), .rsp_rdata_o(a_rsp_rdata),
      .init_done_o(a_init_done), .ram_wr_n_o(a_ram_wr_n), .ram_address_o(a_ram_address),
      .ram_wdata_o(a_ram_wdata), .ram_rdata_i(a_ram_rdata));

   ram8x72_ctrl #(.INIT_EN(1'b0), .RD_LAT(1)) u_b (
      .clk_i(clk), .rst_i(b_rst),
      .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_write_i(b_req_write),
      .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata),
      .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_rdata_o(b_rsp_rdata),
      .init_done_o(b_init_done), .ram_wr_n_o(b_ram_wr_n), .ram_address_o(b_ram_address),
      .ram_wdata_o(b_ram_wdata), .ram_rdata_i(b_ram_rdata));

   // RAM models: A has one read pipeline register (RD_LAT=2), B reads combinationally.
   logic        preload = 1'b1;
   logic [71:0] mem_a [8];
   logic [71:0] mem_b [8];
   logic [71:0] a_rd_pipe;
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 8; i++) begin
            mem_a[i] <= 72'hBAD0 + 72'(i);
            mem_b[i] <= 72'hBEE0 + 72'(i);
         end
      end else begin
         if (!a_ram_wr_n) mem_a[a_ram_address] <= a_ram_wdata;
         if (!b_ram_wr_n) mem_b[b_ram_address] <= b_ram_wdata;
      end
      a_rd_pipe <= mem_a[a_ram_address];
   end
   assign a_ram_rdata = a_rd_pipe;
   assign b_ram_rdata = mem_b[b_ram_address];

   int chk_cnt = 0;
   int pass_cnt = 0;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_wait_ready(input string name);
      int n = 0;
      while (!a_req_ready && n < 40) begin tick(); n++; end
      if (!a_req_ready) check({name, " ready timeout"}, 72'(a_req_ready), 72'd1);
   endtask

   task automatic a_write(input logic [2:0] ad, input logic [71:0] d);
      a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = ad; a_req_wdata = d;
      a_wait_ready("wr");
      tick();
      a_req_valid = 1'b0;
      check("wr wr_n low", 72'(a_ram_wr_n), 72'd0);
      check("wr addr", 72'(a_ram_address), 72'(ad));
      check("wr data", a_ram_wdata, d);
      tick();
      check("wr wr_n released", 72'(a_ram_wr_n), 72'd1);
      check("wr ready back", 72'(a_req_ready), 72'd1);
   endtask

   // lat counts cycles from the handshake cycle to the first cycle showing rsp_valid.
   task automatic a_read(input logic [2:0] ad, output logic [71:0] d, output int lat);
      a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = ad;
      a_wait_ready("rd");
      tick();
      a_req_valid = 1'b0;
      lat = 1;
      while (!a_rsp_valid && lat < 20) begin tick(); lat++; end
      d = a_rsp_rdata;
      if (a_rsp_ready) tick();
   endtask

   typedef struct {
      bit          wr;
      logic [2:0]  addr;
      logic [71:0] data;
   } vec_t;

   vec_t        vecs [19];
   logic [71:0] rd;
   int          lat;
   int          lows;
   bit          saw_valid;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{wr: 1'b0, addr: 3'd5, data: 72'd0};
      for (int i = 0; i < 8; i++) vecs[1 + i] = '{wr: 1'b1, addr: 3'(i), data: 72'(i + 1)};
      for (int i = 0; i < 8; i++) vecs[9 + i] = '{wr: 1'b0, addr: 3'(i), data: 72'(i + 1)};
      vecs[17] = '{wr: 1'b1, addr: 3'd7, data: 72'hFF_0000_0000_0000_00A5};
      vecs[18] = '{wr: 1'b0, addr: 3'd7, data: 72'hFF_0000_0000_0000_00A5};

      a_rst = 1'b1; a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0;
      a_req_wdata = '0; a_rsp_ready = 1'b1;
      b_rst = 1'b1; b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0;
      b_req_wdata = '0; b_rsp_ready = 1'b1;
      tick();
      preload = 1'b0;
      tick();

      check("rst req_ready", 72'(a_req_ready), 72'd0);
      check("rst rsp_valid", 72'(a_rsp_valid), 72'd0);
      check("rst rsp_rdata", a_rsp_rdata, 72'd0);
      check("rst init_done", 72'(a_init_done), 72'd0);
      check("rst wr_n", 72'(a_ram_wr_n), 72'd1);
      check("rst address", 72'(a_ram_address), 72'd0);
      check("rst wdata", a_ram_wdata, 72'd0);

      // Init sweep: eight write cycles over addresses 0..7, then IDLE.
      a_rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         check($sformatf("init wr_n %0d", i), 72'(a_ram_wr_n), 72'd0);
         check($sformatf("init addr %0d", i), 72'(a_ram_address), 72'(i));
         check($sformatf("init data %0d", i), a_ram_wdata, 72'd0);
         check($sformatf("init ready %0d", i), 72'(a_req_ready), 72'd0);
      end
      tick();
      check("init end wr_n", 72'(a_ram_wr_n), 72'd1);
      check("init_done", 72'(a_init_done), 72'd1);
      check("init end ready", 72'(a_req_ready), 72'd1);

      foreach (vecs[i]) begin
         if (vecs[i].wr) a_write(vecs[i].addr, vecs[i].data);
         else begin
            a_read(vecs[i].addr, rd, lat);
            check($sformatf("vec %0d rdata", i), rd, vecs[i].data);
            check($sformatf("vec %0d latency", i), 72'(lat), 72'd3);
         end
      end

      // Response held under backpressure; a competing request is ignored.
      a_rsp_ready = 1'b0;
      a_read(3'd3, rd, lat);
      check("hold first rdata", rd, 72'd4);
      a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 3'd3; a_req_wdata = 72'hDEAD;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("hold valid %0d", i), 72'(a_rsp_valid), 72'd1);
         check($sformatf("hold rdata %0d", i), a_rsp_rdata, 72'd4);
         check($sformatf("hold ready %0d", i), 72'(a_req_ready), 72'd0);
         check($sformatf("hold wr_n %0d", i), 72'(a_ram_wr_n), 72'd1);
      end
      a_req_valid = 1'b0;
      a_rsp_ready = 1'b1;
      tick();
      check("release valid", 72'(a_rsp_valid), 72'd0);
      check("release ready", 72'(a_req_ready), 72'd1);
      a_read(3'd3, rd, lat);
      check("ignored write had no effect", rd, 72'd4);

      // Reset one cycle after a read is accepted.
      a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 3'd2;
      a_wait_ready("rst rd");
      tick();
      a_req_valid = 1'b0;
      a_rst = 1'b1;
      tick();
      a_rst = 1'b0;
      check("rst mid-read valid", 72'(a_rsp_valid), 72'd0);
      lows = 0; saw_valid = 1'b0;
      for (int i = 0; i < 9; i++) begin
         tick();
         if (!a_ram_wr_n) lows++;
         if (a_rsp_valid) saw_valid = 1'b1;
      end
      check("re-init write cycles", 72'(lows), 72'd8);
      check("re-init rsp_valid seen", 72'(saw_valid), 72'd0);
      check("re-init done", 72'(a_init_done), 72'd1);
      check("re-init ready", 72'(a_req_ready), 72'd1);
      a_read(3'd2, rd, lat);
      check("re-init addr2", rd, 72'd0);
      a_read(3'd7, rd, lat);
      check("re-init addr7", rd, 72'd0);

      // INIT_EN=0, RD_LAT=1 instance.
      b_rst = 1'b0;
      tick();
      check("b ready after reset", 72'(b_req_ready), 72'd1);
      check("b wr_n idle", 72'(b_ram_wr_n), 72'd1);
      b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 3'd2; b_req_wdata = 72'd9;
      tick();
      b_req_valid = 1'b0;
      check("b wr wr_n", 72'(b_ram_wr_n), 72'd0);
      check("b wr addr", 72'(b_ram_address), 72'd2);
      tick();
      check("b wr release", 72'(b_ram_wr_n), 72'd1);
      check("b wr ready", 72'(b_req_ready), 72'd1);
      b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 3'd2;
      tick();
      b_req_valid = 1'b0;
      check("b rd not yet valid", 72'(b_rsp_valid), 72'd0);
      tick();
      check("b rd valid", 72'(b_rsp_valid), 72'd1);
      check("b rd data", b_rsp_rdata, 72'd9);
      tick();
      check("b rsp consumed", 72'(b_rsp_valid), 72'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
